key_debounce_pulse: RTL

Input conditioner for the lab FSMs: takes a raw, bouncing, asynchronous push-button/switch level and produces a clean debounced level plus single-cycle press/release strobes. Sits directly upstream of the 3-state output FSM and drives its `in`. A strobe can instead serve as the FSM's step enable. Internally it is a 2-flop synchroniser followed by a 4-state debounce FSM with a stability counter.

---
 rtl/key_debounce_pulse_pkg.sv | 15 +
 rtl/key_debounce_pulse_sync_2ff.sv | 30 +++
 rtl/key_debounce_pulse.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for the key debouncer: FSM state encodings (also used by
// downstream FSM benches to decode the debug state) and a counter-width helper.
package key_debounce_pulse_pkg;

  localparam logic [1:0] ST_IDLE         = 2'b00;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] ST_PRESSED      = 2'b10;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;

  // Width of a counter that must hold 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_pulse_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous lab inputs; both flops reset
// to RESET_VAL so the idle level is presented straight out of reset.
module key_debounce_pulse_sync_2ff
  import key_debounce_pulse_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments so the second flop takes the first flop's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: synchroniser + 4-state debounce FSM giving a clean
// level and press/release strobes. Define LONG_PRESS_EN to add the long-press strobe.
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] state
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
    $error("key_debounce_pulse: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  logic          raw_sync;
  logic          key_sync;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  key_debounce_pulse_sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (key_raw),
    .q_o (raw_sync)
  );

  assign key_sync = raw_sync ^ ACTIVE_LOW;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_sync) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key_sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!key_sync) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key_sync) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_DONE = LW'(LONG_CYCLES);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          long_q, long_d;

  // Holds through RELEASE_WAIT bounces; parks at LONG_DONE so one press fires once.
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    if (state_q == ST_PRESSED) begin
      if (lcnt_q == LONG_LAST) begin
        lcnt_d = LONG_DONE;
        long_d = 1'b1;
      end else if (lcnt_q != LONG_DONE) begin
        lcnt_d = lcnt_q + 1'b1;
      end
    end else if (state_q != ST_RELEASE_WAIT) begin
      lcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign state         = state_q;

endmodule
